afifo_rd_ctrl: RTL and testbench
================================

// Module: afifo_rd_ctrl
// PURPOSE
//  Read-side pointer/flag controller of the async FIFO, running in the read clock domain.
//  Owns the read pointer in binary and Gray form and drives the dual-port RAM read address.
//  Consumes the write pointer (Gray) after the 2-flop synchronizer.
//  Produces the registered empty flag, read-data-valid strobe and sticky underflow flag.
//  Its rptr_gray output feeds the synchronizer into the write domain.
// PARAMETERS
//  ADDR_W   4   RAM address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits
// PORTS
//  clk              in   1         read-domain clock
//  rst              in   1         reset, asynchronous, active-high
//  rd_en            in   1         read request from consumer
//  wptr_gray_sync   in   ADDR_W+1  write pointer, Gray, already synchronized to clk
//  rd_addr          out  ADDR_W    RAM read address = rbin[ADDR_W-1:0]
//  rptr_gray        out  ADDR_W+1  registered read pointer, Gray, to write-side synchronizer
//  empty            out  1         registered FIFO-empty flag
//  rd_valid         out  1         RAM read data valid (1 cycle after accepted read)
//  underflow        out  1         sticky: rd_en seen while empty
//  rd_level         out  ADDR_W+1  occupancy seen by reader (only with AFIFO_RD_LEVEL_EN)
// BEHAVIOUR
//  - Reset (async, immediate): rbin=0, rptr_gray=0, empty=1, rd_valid=0, underflow=0, rd_level=0.
//  - rd_fire = rd_en & ~empty (combinational). Reads while empty are ignored: pointers hold.
//  - rbin_next = rbin + rd_fire, computed mod 2**(ADDR_W+1).
//  - rgray_next = rbin_next ^ (rbin_next >> 1).
//  - Both rbin and rptr_gray register on every clk edge.
//  - rptr_gray is a pure flop output with no combinational path; at most one bit changes per cycle.
//  - empty <= (rgray_next == wptr_gray_sync). Compare is full-width, MSB included.
//    empty therefore updates in the same edge as the pointer, so back-to-back reads cannot overrun.
//  - rd_addr = rbin[ADDR_W-1:0]. RAM is synchronous with 1-cycle read latency.
//  - rd_valid <= rd_fire. Data for read N is valid in the cycle rd_valid is high.
//  - underflow <= underflow | (rd_en & empty). Only reset clears it.
//  - Wrap-around:
//    - rbin rolls from 2**(ADDR_W+1)-1 to 0.
//    - Gray wrap is a single-bit change (e.g. ADDR_W=4: 5'b10000 -> 5'b00000).
//    - The extra MSB separates full from empty; empty never asserts spuriously at address wrap.
//  - Empty is pessimistic by design:
//    - A write becomes visible only after the synchronizer latency (2 clk).
//    - empty may stay high for 2-3 cycles after a write; it never deasserts early.
//  - A wptr_gray_sync change in the same cycle as a read is handled by the same compare.
//    Result reflects both events.
//  - Reset mid-operation: all state returns to reset values at once; in-flight rd_valid is dropped.
//    The write side must be reset together with this block.
// CONFIGURATION
//  AFIFO_RD_LEVEL_EN defined:
//    - wbin = gray2bin(wptr_gray_sync), an XOR prefix from the MSB down.
//    - rd_level <= wbin - rbin_next, mod 2**(ADDR_W+1). Range 0..2**ADDR_W, registered.
//  AFIFO_RD_LEVEL_EN undefined:
//    - rd_level is tied to 0 and no gray2bin logic is built. All other behaviour is unchanged.
// TESTING
//  1 Reset: rst=1 with rd_en=1 -> empty=1, rptr_gray=0, rd_addr=0, rd_valid=0, underflow=0.
//  2 Single entry, ADDR_W=4: wptr_gray_sync 0->1, then rd_en=1 for 1 cycle
//    -> empty falls the edge after 1 is sampled; one read; rd_addr 0->1, rptr_gray=00001;
//    -> empty=1 again; rd_valid high exactly 1 cycle, one cycle after rd_fire.
//  3 Underflow: rd_en=1 while empty=1 -> pointers unchanged, rd_valid=0;
//    -> underflow=1 and stays 1 after rd_en drops, until rst.
//  4 Wrap: preload wptr via writes to 33 entries total over time; drain all
//    -> rbin passes 31->0, rptr_gray 10000->00000 single-bit change;
//    -> empty=1 exactly when the pointers match, never at the wrap.
//  5 Simultaneous events: one entry left, rd_en=1 in the same cycle wptr_gray_sync advances by 1
//    -> empty stays 0, and one further read succeeds.
//  6 With AFIFO_RD_LEVEL_EN: wptr_gray_sync = gray(9), rbin=3, no read -> rd_level=6 next cycle;
//    full (16 entries) -> rd_level=16.

Source files
------------

// File: rtl/afifo_rd_ctrl.sv
// Read-side pointer and flag controller of the async FIFO, clocked in the read domain.
// Optional occupancy output rd_level is built only when AFIFO_RD_LEVEL_EN is defined.
module afifo_rd_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wptr_gray_sync,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   rptr_gray,
    output logic              empty,
    output logic              rd_valid,
    output logic              underflow,
    output logic [ADDR_W:0]   rd_level
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic          rd_fire;

    // Reads against an empty FIFO are dropped; the pointer only moves on rd_fire.
    assign rd_fire    = rd_en & ~empty;
    assign rbin_next  = rbin + PW'(rd_fire);
    assign rgray_next = rbin_next ^ (rbin_next >> 1);

    // Empty is evaluated against the next pointer so it moves on the same edge as the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin      <= '0;
            rptr_gray <= '0;
            empty     <= 1'b1;
            rd_valid  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rbin      <= rbin_next;
            rptr_gray <= rgray_next;
            empty     <= (rgray_next == wptr_gray_sync);
            rd_valid  <= rd_fire;
            underflow <= underflow | (rd_en & empty);
        end
    end

    assign rd_addr = rbin[ADDR_W-1:0];

`ifdef AFIFO_RD_LEVEL_EN
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin;
    logic [PW-1:0] rd_level_q;

    assign wbin = gray2bin(wptr_gray_sync);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_level_q <= '0;
        end else begin
            rd_level_q <= wbin - rbin_next;
        end
    end

    assign rd_level = rd_level_q;
`else
    assign rd_level = '0;
`endif

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// Self-checking bench for afifo_rd_ctrl; the write side is modelled by driving wptr_gray_sync.
// Read addresses are scoreboarded: pushed when a read is issued, popped when rd_valid appears.
module tb_afifo_rd_ctrl;

    localparam int ADDR_W = 4;
    localparam int PW     = ADDR_W + 1;
    localparam int PMASK  = (1 << PW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rd_en = 1'b0;
    logic [PW-1:0]     wptr_gray_sync = '0;
    logic [ADDR_W-1:0] rd_addr;
    logic [PW-1:0]     rptr_gray;
    logic              empty;
    logic              rd_valid;
    logic              underflow;
    logic [PW-1:0]     rd_level;

    int errors = 0;
    int checks = 0;

    int rb = 0;
    int wb = 0;
    bit exp_empty = 1'b1;
    bit exp_uf    = 1'b0;
    bit exp_valid = 1'b0;
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] prev_addr = '0;

    afifo_rd_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_en          (rd_en),
        .wptr_gray_sync (wptr_gray_sync),
        .rd_addr        (rd_addr),
        .rptr_gray      (rptr_gray),
        .empty          (empty),
        .rd_valid       (rd_valid),
        .underflow      (underflow),
        .rd_level       (rd_level)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] gray(input int b);
        logic [PW-1:0] v;
        v = b[PW-1:0];
        return v ^ (v >> 1);
    endfunction

    function automatic logic [PW-1:0] exp_level();
`ifdef AFIFO_RD_LEVEL_EN
        int d;
        d = (wb - rb) & PMASK;
        return d[PW-1:0];
`else
        return '0;
`endif
    endfunction

    // Scoreboard: the address presented in the cycle of the read is checked when rd_valid rises.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_valid_unexpected: rd_valid=1 with no read outstanding, addr=%0d", prev_addr);
            end else begin
                if (prev_addr !== exp_q[0]) begin
                    errors++;
                    $display("FAIL read_addr: got %0d expected %0d", prev_addr, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        prev_addr <= rd_addr;
    end

    task automatic set_wptr(input int n);
        wb = n;
        wptr_gray_sync = gray(n);
    endtask

    task automatic cycle(input bit rde);
        bit fire;
        rd_en = rde;
        fire  = rde && !exp_empty;
        if (rde && exp_empty) exp_uf = 1'b1;
        if (fire) begin
            exp_q.push_back(rb[ADDR_W-1:0]);
            rb++;
        end
        exp_valid = fire;
        @(posedge clk);
        #1;
        exp_empty = ((rb & PMASK) == (wb & PMASK));
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rd_en = 1'b0;
        rst = 1'b1;
        wptr_gray_sync = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rb = 0;
        wb = 0;
        exp_empty = 1'b1;
        exp_uf = 1'b0;
        exp_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rd_en = 1'b1;
        wptr_gray_sync = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++;
        if (rptr_gray !== '0) begin errors++; $display("FAIL reset_rptr_gray: got %b expected 00000", rptr_gray); end
        checks++;
        if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
        checks++;
        if (rd_level !== '0) begin errors++; $display("FAIL reset_rd_level: got %0d expected 0", rd_level); end
        do_reset();
    endtask

    task automatic test_single_entry();
        do_reset();
        set_wptr(1);
        cycle(1'b0);
        checks++;
        if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_fall: got %b expected 0", empty); end
        cycle(1'b1);
        checks++;
        if (rd_addr !== 4'd1) begin errors++; $display("FAIL single_rd_addr: got %0d expected 1", rd_addr); end
        checks++;
        if (rptr_gray !== 5'b00001) begin errors++; $display("FAIL single_rptr_gray: got %b expected 00001", rptr_gray); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_again: got %b expected 1", empty); end
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_rd_valid_hi: got %b expected 1", rd_valid); end
        cycle(1'b0);
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_rd_valid_lo: got %b expected 0", rd_valid); end
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(1'b1);
        checks++;
        if (rptr_gray !== '0 || rd_addr !== '0) begin
            errors++;
            $display("FAIL uf_pointer_hold: gray=%b addr=%0d expected 00000/0", rptr_gray, rd_addr);
        end
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL uf_rd_valid: got %b expected 0", rd_valid); end
        checks++;
        if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", underflow); end
        repeat (3) cycle(1'b0);
        checks++;
        if (underflow !== exp_uf) begin errors++; $display("FAIL uf_sticky: got %b expected %b", underflow, exp_uf); end
        do_reset();
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL uf_cleared_by_rst: got %b expected 0", underflow); end
    endtask

    task automatic test_wrap();
        int targets[3] = '{10, 26, 33};
        logic [PW-1:0] prev_gray;
        do_reset();
        prev_gray = rptr_gray;
        foreach (targets[k]) begin
            set_wptr(targets[k]);
            cycle(1'b0);
            while (!exp_empty) begin
                cycle(1'b1);
                checks++;
                if (empty !== exp_empty) begin
                    errors++;
                    $display("FAIL wrap_empty: rb=%0d wb=%0d got %b expected %b", rb, wb, empty, exp_empty);
                end
                checks++;
                if (rptr_gray !== gray(rb) || $countones(rptr_gray ^ prev_gray) > 1) begin
                    errors++;
                    $display("FAIL wrap_gray: rb=%0d got %b prev %b expected %b", rb, rptr_gray, prev_gray, gray(rb));
                end
                if (rb == 32) begin
                    checks++;
                    if (prev_gray !== 5'b10000 || rptr_gray !== 5'b00000) begin
                        errors++;
                        $display("FAIL wrap_point: got %b->%b expected 10000->00000", prev_gray, rptr_gray);
                    end
                end
                prev_gray = rptr_gray;
            end
        end
        checks++;
        if (rb != 33 || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_drained: reads=%0d empty=%b expected 33/1", rb, empty);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_wptr(1);
        cycle(1'b0);
        set_wptr(2);
        cycle(1'b1);
        checks++;
        if (empty !== 1'b0) begin errors++; $display("FAIL simul_empty_stays_low: got %b expected 0", empty); end
        cycle(1'b1);
        checks++;
        if (rd_valid !== 1'b1 || rd_addr !== 4'd2) begin
            errors++;
            $display("FAIL simul_second_read: valid=%b addr=%0d expected 1/2", rd_valid, rd_addr);
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty_end: got %b expected 1", empty); end
        cycle(1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_wptr(5);
        cycle(1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1);
            checks++;
            if (rd_valid !== 1'b1 || empty !== exp_empty) begin
                errors++;
                $display("FAIL b2b_read%0d: valid=%b empty=%b expected 1/%b", i, rd_valid, empty, exp_empty);
            end
        end
        cycle(1'b0);
        checks++;
        if (rd_valid !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: valid=%b underflow=%b expected 0/0", rd_valid, underflow);
        end
    endtask

    task automatic test_level();
        do_reset();
        set_wptr(3);
        cycle(1'b0);
        repeat (3) cycle(1'b1);
        set_wptr(9);
        cycle(1'b0);
        checks++;
        if (rd_level !== exp_level()) begin
            errors++;
            $display("FAIL level_six: got %0d expected %0d", rd_level, exp_level());
        end
        set_wptr(19);
        cycle(1'b0);
        checks++;
        if (rd_level !== exp_level()) begin
            errors++;
            $display("FAIL level_full: got %0d expected %0d", rd_level, exp_level());
        end
        cycle(1'b1);
        checks++;
        if (rd_level !== exp_level()) begin
            errors++;
            $display("FAIL level_after_read: got %0d expected %0d", rd_level, exp_level());
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        set_wptr(4);
        cycle(1'b0);
        cycle(1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || empty !== 1'b1 || rptr_gray !== '0 || rd_addr !== '0 || rd_level !== '0) begin
            errors++;
            $display("FAIL reset_mid_op: valid=%b empty=%b gray=%b addr=%0d level=%0d expected 0/1/0/0/0",
                     rd_valid, empty, rptr_gray, rd_addr, rd_level);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_entry();
        test_underflow();
        test_wrap();
        test_simultaneous();
        test_back_to_back();
        test_level();
        test_reset_mid_op();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reads_outstanding: %0d reads never saw rd_valid", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
